cntr_checker: RTL and testbench
===============================

Name: cntr_checker

Overview:
- Receive-side monitor for the free-running N-bit `cntr` count stream.
- Samples a qualified count value and checks that each sample is the previous value +1, with modulo-2^N wrap.
- Reports lock status, per-error pulses, a saturating error count and a stall timeout.
- Sits at the consumer end of any counter-driven link. Used both in-system and as a self-checking monitor in counter benches.

Parameters:
- N, 8, count width; must match the producing counter.
- LOCK_LEN, 4, consecutive correct increments required to declare lock (≥1).
- ERR_W, 8, width of the saturating error counter.
- TMO_CYC, 64, cycles without in_valid while locked before timeout; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  cnt_in is a sample this cycle.
- cnt_in  in  N  sampled count value.
- clr_stats  in  1  synchronous clear of err_count and tmo_flag.
- locked  out  1  checker is locked to the stream.
- err_pulse  out  1  one-cycle pulse per mismatch detected while locked.
- err_count  out  ERR_W  saturating mismatch count.
- tmo_flag  out  1  sticky: lock lost due to input stall.
- last_val  out  N  most recent accepted sample.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - locked=0, err_pulse=0, err_count=0, tmo_flag=0, last_val=0.
  - run_len=0, idle_cnt=0.
- All outputs are registered. Every response appears one clock after the sample that causes it.
- Expected value: exp = last_val + 1, truncated to N bits. 2^N−1 → 0 is a correct increment.
- Every valid sample updates last_val <= cnt_in, whether it matches or not.
- FSM states: IDLE, ACQ, LOCK.
  - IDLE:
    - in_valid=1 → last_val<=cnt_in, run_len<=0, go to ACQ.
    - No comparison is made in IDLE.
  - ACQ:
    - in_valid=1 and match → run_len++.
    - If run_len+1 == LOCK_LEN → go to LOCK and set locked=1 on the next edge.
    - in_valid=1 and mismatch → run_len<=0, stay in ACQ. No err_pulse and no count increment in ACQ.
    - in_valid=0 → hold state.
  - LOCK:
    - in_valid=1 and match → stay, idle_cnt<=0.
    - in_valid=1 and mismatch → err_pulse=1 for one cycle, err_count+1 (saturating at 2^ERR_W−1), locked<=0, run_len<=0, go to ACQ.
    - in_valid=0 → idle_cnt++. If TMO_CYC≠0 and idle_cnt+1 == TMO_CYC → locked<=0, tmo_flag<=1, go to IDLE.
- idle_cnt is cleared on any valid sample and on leaving LOCK.
- run_len is wide enough for LOCK_LEN, and it does not count in LOCK.
- clr_stats:
  - Clears err_count and tmo_flag next edge. It does not change state, locked or last_val.
  - Same cycle as a LOCK mismatch → err_count=1 and err_pulse=1.
  - Same cycle as a timeout → tmo_flag=1 (set wins).
- Saturation: at max, err_count holds its value; err_pulse still fires.
- Reset asserted mid-stream → immediate return to reset values. Reacquisition starts from IDLE after release.
- LOCK_LEN=1 → one correct increment after the first sample locks.

Decomposition:
- Shared package `cntr_pkg`:
  - state enum: IDLE=2'd0, ACQ=2'd1, LOCK=2'd2.
  - Default N.
  - Helper function for the next-count value, shared with `cntr`.
- One sub-module is natural: `sat_cntr` (parameter W; inputs inc and clr; output saturating count), used for err_count.
- The timeout counter stays inline.

Test Plan:
- Reset low, then driven 0..9 with in_valid=1 every cycle (N=8, LOCK_LEN=4) → locked rises one clock after the sample 4; err_count=0; last_val=9.
- Locked stream 0xFD,0xFE,0xFF,0x00,0x01 → no err_pulse; locked stays 1 across the wrap.
- Locked at 0x10, then driven 0x11,0x15,0x16… → err_pulse is a single cycle after 0x15; err_count=1; locked=0; relocks one clock after the sample 0x19 (4 matches after 0x15).
- Locked, then in_valid held 0 for 64 cycles (TMO_CYC=64) → locked=0, tmo_flag=1, state IDLE. 63 cycles then a valid matching sample → still locked, tmo_flag=0.
- ERR_W=2: five mismatches while locked (relocking between each) → err_count goes 1,2,3,3,3; five err_pulses. clr_stats together with a sixth mismatch → err_count=1.
- reset pulsed low while locked → all outputs are 0 immediately. After release, 4 correct increments are needed to relock.

Source files
------------

// File: rtl/cntr_pkg.sv
// Shared definitions for the free-running cntr producer and its receive-side checker.
package cntr_pkg;

  localparam int CNTR_N_DEFAULT = 8;
  localparam int CNTR_MAX_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } chk_state_e;

  // Successor of a count value; truncating the result to N bits gives the modulo-2^N wrap.
  function automatic logic [CNTR_MAX_W-1:0] next_count(input logic [CNTR_MAX_W-1:0] val);
    return val + CNTR_MAX_W'(1);
  endfunction

endpackage

// File: rtl/sat_cntr.sv
// Saturating up-counter with synchronous clear; a clear and an increment together yield 1.
module sat_cntr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  // NOTE: assign every always_comb output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (clr_i) count_d = '0;
    if (inc_i && (count_d != '1)) count_d = count_d + W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/cntr_checker.sv
// Receive-side monitor for an N-bit free-running count stream: acquires lock, flags
// increment errors, counts them with saturation and drops lock on an input stall.
module cntr_checker
  import cntr_pkg::*;
#(
  parameter int N        = CNTR_N_DEFAULT,
  parameter int LOCK_LEN = 4,
  parameter int ERR_W    = 8,
  parameter int TMO_CYC  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [N-1:0]     cnt_in,
  input  logic             clr_stats,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             tmo_flag,
  output logic [N-1:0]     last_val
);

  localparam int RUN_W = $clog2(LOCK_LEN + 1);
  localparam int TMO_W = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;

  chk_state_e       state_q, state_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic [TMO_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [N-1:0]     last_val_q, last_val_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             tmo_flag_q, tmo_flag_d;
  logic [N-1:0]     exp_val;
  logic             match;
  logic             err_inc;
  logic             tmo_set;

  assign exp_val = N'(next_count(CNTR_MAX_W'(last_val_q)));
  assign match   = (cnt_in == exp_val);

  always_comb begin
    state_d    = state_q;
    run_len_d  = run_len_q;
    idle_cnt_d = in_valid ? '0 : idle_cnt_q;
    last_val_d = in_valid ? cnt_in : last_val_q;
    err_inc    = 1'b0;
    tmo_set    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          run_len_d = '0;
          state_d   = ACQ;
        end
      end
      ACQ: begin
        if (in_valid) begin
          if (!match) begin
            run_len_d = '0;
          end else if (int'(run_len_q) + 1 == LOCK_LEN) begin
            run_len_d = '0;
            state_d   = LOCK;
          end else begin
            run_len_d = run_len_q + RUN_W'(1);
          end
        end
      end
      LOCK: begin
        if (in_valid) begin
          if (!match) begin
            err_inc   = 1'b1;
            run_len_d = '0;
            state_d   = ACQ;
          end
        end else if (TMO_CYC != 0) begin
          if (int'(idle_cnt_q) + 1 == TMO_CYC) begin
            tmo_set    = 1'b1;
            idle_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            idle_cnt_d = idle_cnt_q + TMO_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    locked_d    = (state_d == LOCK);
    err_pulse_d = err_inc;
    // A timeout in the same cycle as a clear must still leave the flag set.
    tmo_flag_d  = tmo_set | (tmo_flag_q & ~clr_stats);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      run_len_q   <= '0;
      idle_cnt_q  <= '0;
      last_val_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      tmo_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_len_q   <= run_len_d;
      idle_cnt_q  <= idle_cnt_d;
      last_val_q  <= last_val_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      tmo_flag_q  <= tmo_flag_d;
    end
  end

  sat_cntr #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (err_inc),
    .clr_i   (clr_stats),
    .count_o (err_count)
  );

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign tmo_flag  = tmo_flag_q;
  assign last_val  = last_val_q;

endmodule

// File: tb/tb_cntr_checker.sv
// Self-checking bench for cntr_checker: directed scenarios plus random traffic, compared
// every cycle against a sample-history model for an 8-bit and a 2-bit error-count instance.
module tb_cntr_checker;

  localparam int LOCK_LEN = 4;
  localparam int TMO_CYC  = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       clr_stats = 1'b0;
  logic [7:0] cnt_in = 8'd0;

  logic       locked_a, err_pulse_a, tmo_a;
  logic [7:0] err_a, last_a;
  logic       locked_b, err_pulse_b, tmo_b;
  logic [1:0] err_b;
  logic [7:0] last_b;

  int n_checks = 0;
  int n_errors = 0;

  // Model: remembers the last sample, the current run of good increments and whether we are locked.
  bit m_have   = 0;
  bit m_locked = 0;
  bit m_pulse  = 0;
  bit m_tmo    = 0;
  int m_last   = 0;
  int m_streak = 0;
  int m_stall  = 0;
  int m_err    = 0;

  logic [7:0] cur = 8'd0;

  always #5 clk = ~clk;

  cntr_checker u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .cnt_in    (cnt_in),
    .clr_stats (clr_stats),
    .locked    (locked_a),
    .err_pulse (err_pulse_a),
    .err_count (err_a),
    .tmo_flag  (tmo_a),
    .last_val  (last_a)
  );

  cntr_checker #(
    .ERR_W (2)
  ) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .cnt_in    (cnt_in),
    .clr_stats (clr_stats),
    .locked    (locked_b),
    .err_pulse (err_pulse_b),
    .err_count (err_b),
    .tmo_flag  (tmo_b),
    .last_val  (last_b)
  );

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit good;
    m_pulse = 0;
    if (clr_stats) begin
      m_err = 0;
      m_tmo = 0;
    end
    if (in_valid) begin
      good = (cnt_in == 8'((m_last + 1) % 256));
      if (!m_have) begin
        m_have   = 1;
        m_streak = 0;
      end else if (m_locked) begin
        if (!good) begin
          m_locked = 0;
          m_streak = 0;
          m_err++;
          m_pulse = 1;
        end
      end else if (good) begin
        m_streak++;
        if (m_streak == LOCK_LEN) m_locked = 1;
      end else begin
        m_streak = 0;
      end
      m_last  = int'(cnt_in);
      m_stall = 0;
    end else if (m_locked) begin
      m_stall++;
      if (m_stall == TMO_CYC) begin
        m_locked = 0;
        m_have   = 0;
        m_tmo    = 1;
        m_stall  = 0;
      end
    end
  endtask

  always @(negedge reset) begin
    m_have = 0; m_locked = 0; m_pulse = 0; m_tmo = 0;
    m_last = 0; m_streak = 0; m_stall = 0; m_err = 0;
  end

  always @(posedge clk) if (reset) model_step();

  always @(negedge clk) begin
    check("locked",      locked_a,    m_locked);
    check("err_pulse",   err_pulse_a, m_pulse);
    check("err_count",   err_a,       sat(m_err, 255));
    check("tmo_flag",    tmo_a,       m_tmo);
    check("last_val",    last_a,      m_last);
    check("locked_w2",   locked_b,    m_locked);
    check("err_pulse_w2", err_pulse_b, m_pulse);
    check("err_count_w2", err_b,      sat(m_err, 3));
  end

  task automatic drive(input logic v, input logic [7:0] c, input logic clr);
    @(negedge clk);
    in_valid  = v;
    cnt_in    = c;
    clr_stats = clr;
    if (v) cur = c;
  endtask

  task automatic send(input logic [7:0] c);
    drive(1'b1, c, 1'b0);
  endtask

  task automatic stall(input int n);
    repeat (n) drive(1'b0, 8'($urandom), 1'b0);
  endtask

  int exp_w2 [6] = '{1, 2, 3, 3, 3, 1};

  initial begin
    logic [7:0] b;
    int r;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_locked", locked_a, 0);
    check("rst_last",   last_a,   0);
    check("rst_err",    err_a,    0);
    check("rst_tmo",    tmo_a,    0);
    reset = 1'b1;

    // Acquisition from 0..9
    for (int i = 0; i <= 4; i++) send(8'(i));
    check("lock_early", locked_a, 0);
    send(8'd5);
    check("lock_on_4", locked_a, 1);
    for (int i = 6; i <= 9; i++) send(8'(i));
    stall(1);
    check("seq_last", last_a, 9);
    check("seq_err",  err_a,  0);
    check("pin_model_last",   m_last,   9);
    check("pin_model_locked", m_locked, 1);

    // Mismatch, relock, then run across the 0xFF -> 0x00 wrap
    send(8'hF8);
    send(8'hF9);
    check("pin_err1", err_a, 1);
    check("pin_pulse1", err_pulse_a, 1);
    check("pin_unlock1", locked_a, 0);
    for (int i = 8'hFA; i <= 8'hFC; i++) send(8'(i));
    send(8'hFD);
    check("relock_fc", locked_a, 1);
    send(8'hFE); send(8'hFF); send(8'h00); send(8'h01); send(8'h02);
    check("wrap_locked", locked_a, 1);
    check("wrap_err",    err_a,    1);

    // Error in the middle of a locked stream
    for (int i = 3; i <= 16'h11; i++) send(8'(i));
    send(8'h15);
    send(8'h16);
    check("jump_pulse",  err_pulse_a, 1);
    check("jump_err",    err_a,       2);
    check("jump_locked", locked_a,    0);
    send(8'h17);
    check("jump_pulse_once", err_pulse_a, 0);
    send(8'h18); send(8'h19); send(8'h1A);
    check("jump_relock", locked_a, 1);

    // Stall just short of the timeout, then a full timeout
    stall(63);
    send(8'h1B);
    check("tmo63_locked", locked_a, 1);
    drive(1'b1, 8'h1C, 1'b1);
    check("tmo63_flag", tmo_a, 0);
    stall(65);
    check("tmo_locked", locked_a, 0);
    check("tmo_flag",   tmo_a,    1);
    check("clr_err",    err_a,    0);
    check("pin_model_tmo", m_tmo, 1);
    drive(1'b0, 8'd0, 1'b1);
    drive(1'b0, 8'd0, 1'b0);
    check("tmo_cleared", tmo_a, 0);

    // Saturation of the 2-bit counter, then clear together with a mismatch
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      for (int j = 0; j < 5; j++) send(8'(b + j));
      drive(1'b1, 8'(b + 7), (k == 5));
      send(8'(b + 8));
      check("w2_count", err_b, exp_w2[k]);
      check("w2_pulse", err_pulse_b, 1);
    end

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      send(8'(cur + 1));
      else if (r < 80) stall(1);
      else if (r < 85) send(8'($urandom));
      else if (r < 88) drive(1'b1, 8'(cur + 1), 1'b1);
      else if (r < 90) stall($urandom_range(55, 70));
      else if (r < 93) drive(1'b0, 8'd0, 1'b1);
      else             send(8'(cur + 1));
    end

    // Reset while locked
    b = 8'($urandom);
    for (int j = 0; j < 5; j++) send(8'(b + j));
    stall(1);
    check("pre_rst_locked", locked_a, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_locked", locked_a,    0);
    check("mid_rst_pulse",  err_pulse_a, 0);
    check("mid_rst_err",    err_a,       0);
    check("mid_rst_tmo",    tmo_a,       0);
    check("mid_rst_last",   last_a,      0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    b = 8'($urandom);
    for (int j = 0; j < 5; j++) send(8'(b + j));
    check("relock_early", locked_a, 0);
    send(8'(b + 5));
    check("relock_rst", locked_a, 1);
    stall(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
